beat_tone_player: RTL and testbench

//  Sequencer and audio engine for the song tables. Steps an 8-bit quarter-beat index at a fixed beat rate and drives it
//  to the song ROM. Reads back the 32-bit tone frequency (Hz) and synthesises a 1-bit square wave at that frequency.

---
 rtl/beat_tone_player_if.sv | 21 ++
 rtl/beat_tone_player.sv | 137 +++++++++++++
 tb/tb_beat_tone_player.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/beat_tone_player_if.sv
// Song-player bus: play controls and tone in from the ROM side, beat index and audio out.
interface beat_tone_player_if;
    logic        en_b;
    logic        pause;
    logic [31:0] tone;
    logic [7:0]  beat_num;
    logic        beat_tick;
    logic        song_done;
    logic        playing;
    logic        audio_out;

    modport master (
        output en_b, pause, tone,
        input  beat_num, beat_tick, song_done, playing, audio_out
    );

    modport slave (
        input  en_b, pause, tone,
        output beat_num, beat_tick, song_done, playing, audio_out
    );
endinterface

// File: rtl/beat_tone_player.sv
// Quarter-beat sequencer for the song ROM plus a phase-accumulator square-wave
// synthesiser that plays the returned tone frequency on a 1-bit audio pin.
module beat_tone_player #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned BEAT_HZ  = 8,
    parameter int unsigned BEAT_LEN = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    beat_tone_player_if.slave   bus
);

    localparam int unsigned BEAT_DIV      = CLK_HZ / BEAT_HZ;
    localparam logic [31:0] BEAT_LAST     = 32'(BEAT_DIV - 1);
    localparam logic [7:0]  BEAT_NUM_LAST = 8'(BEAT_LEN - 1);
    localparam logic [33:0] CLK_HZ_W      = 34'(CLK_HZ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PLAY   = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [31:0] beat_cnt;
    logic [7:0]  beat_num;
    logic        beat_tick;
    logic        song_done;

    logic [31:0] tone_q;
    logic [31:0] tone_prev;
    logic [31:0] acc;
    logic        audio;

    logic        beat_clear;
    logic        beat_run;
    logic [33:0] phase_step;
    logic [33:0] phase_sum;
    logic        silent;
    logic        note_change;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.en_b) next_state = PLAY;
            PLAY: begin
                if (!bus.en_b)     next_state = IDLE;
                else if (bus.pause) next_state = PAUSED;
            end
            PAUSED: begin
                if (!bus.en_b)      next_state = IDLE;
                else if (!bus.pause) next_state = PLAY;
            end
            default: next_state = IDLE;
        endcase
    end

    // ---------------- beat sequencer ----------------
    // The counter advances on every enabled, un-paused cycle outside IDLE, so the
    // PAUSED->PLAY turnaround cycle still counts and a pause of N cycles adds exactly N.
    assign beat_clear = !bus.en_b || (state == IDLE);
    assign beat_run   = bus.en_b && !bus.pause && (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            beat_num  <= '0;
            beat_tick <= 1'b0;
            song_done <= 1'b0;
        end else begin
            beat_tick <= 1'b0;
            song_done <= 1'b0;
            if (beat_clear) begin
                beat_cnt <= '0;
                beat_num <= '0;
            end else if (beat_run) begin
                if (beat_cnt == BEAT_LAST) begin
                    beat_cnt  <= '0;
                    beat_tick <= 1'b1;
                    if (beat_num == BEAT_NUM_LAST) begin
                        beat_num  <= '0;
                        song_done <= 1'b1;
                    end else begin
                        beat_num <= beat_num + 8'd1;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 32'd1;
                end
            end
        end
    end

    // ---------------- tone synthesiser ----------------
    // Adding 2*f per clock and wrapping at CLK_HZ toggles 2*f times per second,
    // giving a square wave of exactly f Hz on average.
    assign phase_step  = {1'b0, tone_q, 1'b0};
    assign phase_sum   = {2'b00, acc} + phase_step;
    assign note_change = (tone_q != tone_prev);
    assign silent      = (tone_q == 32'd0) || (phase_step > CLK_HZ_W) ||
                         (state != PLAY) || bus.pause || !bus.en_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_q    <= '0;
            tone_prev <= '0;
            acc       <= '0;
            audio     <= 1'b0;
        end else begin
            tone_q    <= bus.tone;
            tone_prev <= tone_q;
            if (silent || note_change) begin
                acc   <= '0;
                audio <= 1'b0;
            end else if (phase_sum >= CLK_HZ_W) begin
                acc   <= 32'(phase_sum - CLK_HZ_W);
                audio <= ~audio;
            end else begin
                acc <= phase_sum[31:0];
            end
        end
    end

    assign bus.beat_num  = beat_num;
    assign bus.beat_tick = beat_tick;
    assign bus.song_done = song_done;
    assign bus.playing   = (state == PLAY);
    assign bus.audio_out = audio;

endmodule

// File: tb/tb_beat_tone_player.sv
// Directed bench for beat_tone_player at CLK_HZ=1000, BEAT_HZ=10 (100 clk per beat).
module tb_beat_tone_player;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    beat_tone_player_if bus();

    beat_tone_player #(
        .CLK_HZ  (1000),
        .BEAT_HZ (10),
        .BEAT_LEN(256)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        int first_edge, last_edge, gap_bad, ticks, t1, t2, n;
        int done_cnt, done_cyc, coinc_bad, tk;
        int tmark, bn, audio_bad, move_bad;
        logic [7:0] done_beat, wrap_from, beat_before;
        logic prev, any;
        logic [31:0] silent_tones [3];

        checks = 0; failures = 0; cyc = 0;
        rst_n = 1'b0; bus.en_b = 1'b0; bus.pause = 1'b0; bus.tone = 32'd300;
        #23;
        check("reset_outs", {bus.beat_num, bus.beat_tick, bus.song_done, bus.playing, bus.audio_out}, 0);
        rst_n = 1'b1;

        // idle: everything stays cleared
        any = 1'b0;
        repeat (500) begin
            step();
            any |= (|{bus.beat_num, bus.beat_tick, bus.song_done, bus.playing, bus.audio_out});
        end
        check("idle_outs", any, 0);

        // play at 100 Hz
        bus.tone = 32'd100;
        repeat (3) step();
        bus.en_b = 1'b1;
        cyc = 0;
        step();
        check("play_entry", bus.playing, 1);
        first_edge = -1; last_edge = -1; gap_bad = 0; ticks = 0; t1 = 0; t2 = 0;
        prev = bus.audio_out;
        for (int i = 0; i < 349; i++) begin
            step();
            if (bus.audio_out !== prev) begin
                if (first_edge < 0) first_edge = cyc;
                else if (cyc - last_edge != 5) gap_bad++;
                last_edge = cyc;
                prev = bus.audio_out;
            end
            if (bus.beat_tick) begin
                ticks++;
                if (ticks == 1) t1 = cyc;
                if (ticks == 2) t2 = cyc;
            end
        end
        check("first_edge", first_edge, 6);
        check("edge_gap_bad", gap_bad, 0);
        check("tick1_cyc", t1, 101);
        check("tick2_cyc", t2, 201);
        check("ticks_350", ticks, 3);
        check("beat_num_350", bus.beat_num, 3);

        // song wrap
        done_cnt = 0; done_cyc = 0; coinc_bad = 0; done_beat = 8'hAA; wrap_from = 8'hAA;
        while (cyc < 25700) begin
            beat_before = bus.beat_num;
            step();
            if (bus.song_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_beat = bus.beat_num;
                wrap_from = beat_before;
                if (!bus.beat_tick) coinc_bad++;
            end
        end
        check("song_done_cnt", done_cnt, 1);
        check("song_done_cyc", done_cyc, 25601);
        check("song_done_coinc_bad", coinc_bad, 0);
        check("wrap_to", done_beat, 0);
        check("wrap_from", wrap_from, 255);

        // pause at beat-counter 50 for 30 clk
        n = 0;
        do begin step(); n++; end while (!bus.beat_tick && n < 200);
        check("tick_before_pause", bus.beat_tick, 1);
        tmark = cyc;
        repeat (50) step();
        bus.pause = 1'b1;
        bn = bus.beat_num;
        audio_bad = 0; move_bad = 0;
        repeat (30) begin
            step();
            if (bus.audio_out) audio_bad++;
            if (bus.beat_num != 8'(bn) || bus.beat_tick) move_bad++;
        end
        check("pause_audio_bad", audio_bad, 0);
        check("pause_move_bad", move_bad, 0);
        check("pause_playing", bus.playing, 0);
        bus.pause = 1'b0;
        n = 0;
        do begin step(); n++; end while (!bus.beat_tick && n < 200);
        check("pause_tick_gap", cyc - tmark, 130);
        check("pause_beat_next", bus.beat_num, 8'(bn + 1));

        // pause on the terminal-count cycle
        bn = bus.beat_num;
        repeat (99) step();
        bus.pause = 1'b1;
        step();
        check("tc_pause_no_tick", bus.beat_tick, 0);
        repeat (4) step();
        bus.pause = 1'b0;
        step();
        check("tc_resume_tick", bus.beat_tick, 1);
        check("tc_resume_beat", bus.beat_num, 8'(bn + 1));

        // silent tones
        silent_tones[0] = 32'd0;
        silent_tones[1] = 32'd501;
        silent_tones[2] = 32'd100_000_000;
        for (int k = 0; k < 3; k++) begin
            bus.tone = silent_tones[k];
            repeat (2) step();
            any = 1'b0; tk = 0;
            repeat (200) begin
                step();
                any |= bus.audio_out;
                if (bus.beat_tick) tk++;
            end
            check($sformatf("silent_audio_%0d", k), any, 0);
            check($sformatf("silent_ticks_%0d", k), tk, 2);
        end

        // note change 100 -> 200
        bus.tone = 32'd100;
        repeat (20) step();
        bus.tone = 32'd200;
        step();
        step();
        check("onset_clear", bus.audio_out, 0);
        prev = bus.audio_out; first_edge = -1; n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (bus.audio_out !== prev) begin
                if (first_edge < 0) first_edge = i;
                n++;
                prev = bus.audio_out;
            end
        end
        check("onset_first_edge", first_edge, 3);
        check("onset_toggles_20", n, 8);

        // abort at beat 77
        bus.tone = 32'd100;
        n = 0;
        while (bus.beat_num != 8'd77 && n < 10000) begin step(); n++; end
        check("reach_77", bus.beat_num, 77);
        repeat (30) step();
        bus.en_b = 1'b0;
        step();
        check("abort_beat", bus.beat_num, 0);
        check("abort_playing", bus.playing, 0);
        check("abort_audio", bus.audio_out, 0);

        // asynchronous reset mid-play
        bus.en_b = 1'b1;
        repeat (150) step();
        check("pre_reset_beat", bus.beat_num, 1);
        n = 0;
        while (!bus.audio_out && n < 20) begin step(); n++; end
        check("pre_reset_audio", bus.audio_out, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", {bus.beat_num, bus.beat_tick, bus.song_done, bus.playing, bus.audio_out}, 0);
        #20;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
